// File: rtl/depth_stream_source.sv
// Sample buffer and stream player feeding a depth-increase counter, with
// capture of the counter's final count once it signals completion.
module depth_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  I_CLK,
  input  logic                  I_RSTN,
  input  logic                  I_WR_EN,
  input  logic [DATA_WIDTH-1:0] I_WR_DATA,
  input  logic                  I_CLR,
  input  logic                  I_START,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_LAST,
  output logic                  O_SINK_RSTN,
  input  logic [DATA_WIDTH-1:0] I_RESULT_COUNT,
  input  logic                  I_RESULT_LAST,
  output logic [DATA_WIDTH-1:0] O_RESULT,
  output logic [ADDR_WIDTH:0]   O_LOADED,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_OVF
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_PLAY,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   loaded_q, loaded_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_accept;
  logic                  buf_full;
  logic                  play_last;

  assign buf_full  = (loaded_q == FULL_COUNT);
  assign rd_word   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  // rd_ptr_q runs one ahead of the sample on O_DATA, so it equals the
  // loaded count exactly while the final sample is being presented.
  assign play_last = (state_q == S_PLAY) && (rd_ptr_q == loaded_q);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    loaded_d  = loaded_q;
    rd_ptr_d  = rd_ptr_q;
    data_d    = data_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    wr_accept = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An accepted start freezes the buffer, so a same-cycle clear or
        // write cannot change the length of the run being launched.
        if (I_START && (loaded_q != '0)) begin
          state_d  = S_CLR;
          rd_ptr_d = '0;
          data_d   = '1;
        end else if (I_CLR) begin
          loaded_d = '0;
          ovf_d    = 1'b0;
        end else if (I_WR_EN) begin
          if (buf_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_accept = 1'b1;
            loaded_d  = loaded_q + 1'b1;
          end
        end
      end

      S_CLR: begin
        data_d   = rd_word;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = S_PLAY;
      end

      S_PLAY: begin
        if (play_last) begin
          state_d = S_WAIT;
        end else begin
          data_d   = rd_word;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (I_RESULT_LAST) begin
          result_d = I_RESULT_COUNT;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q  <= S_IDLE;
      loaded_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '1;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: sample storage has no reset; the loaded count alone defines which
  // entries are valid, which keeps the array mappable onto block RAM.
  always_ff @(posedge I_CLK) begin
    if (wr_accept) begin
      mem[loaded_q[ADDR_WIDTH-1:0]] <= I_WR_DATA;
    end
  end

  assign O_DATA      = data_q;
  assign O_LAST      = play_last;
  assign O_SINK_RSTN = (state_q != S_CLR);
  assign O_RESULT    = result_q;
  assign O_LOADED    = loaded_q;
  assign O_BUSY      = (state_q != S_IDLE);
  assign O_DONE      = (state_q == S_DONE);
  assign O_OVF       = ovf_q;

endmodule

// File: tb/tb_depth_stream_source.sv
// Directed plus randomized bench for depth_stream_source, closing the loop
// through a behavioural depth-increase counter attached to the stream port.
module tb_depth_stream_source;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          clr;
  logic          start;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          sink_rstn;
  logic [DW-1:0] res_count;
  logic          res_last;
  logic [DW-1:0] o_result;
  logic [AW:0]   o_loaded;
  logic          o_busy;
  logic          o_done;
  logic          o_ovf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic          model_ovf;

  depth_stream_source #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .I_CLK         (clk),
    .I_RSTN        (rst_n),
    .I_WR_EN       (wr_en),
    .I_WR_DATA     (wr_data),
    .I_CLR         (clr),
    .I_START       (start),
    .O_DATA        (o_data),
    .O_LAST        (o_last),
    .O_SINK_RSTN   (sink_rstn),
    .I_RESULT_COUNT(res_count),
    .I_RESULT_LAST (res_last),
    .O_RESULT      (o_result),
    .O_LOADED      (o_loaded),
    .O_BUSY        (o_busy),
    .O_DONE        (o_done),
    .O_OVF         (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter: counts samples greater than the previous one,
  // resets synchronously on sink_rstn, echoes last two cycles later.
  logic [DW-1:0] sink_cnt;
  logic [DW-1:0] sink_prev;
  logic [1:0]    sink_lp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !sink_rstn) begin
      sink_cnt  <= '0;
      sink_prev <= '1;
      sink_lp   <= '0;
    end else begin
      if (o_data > sink_prev) sink_cnt <= sink_cnt + 1;
      sink_prev <= o_data;
      sink_lp   <= {sink_lp[0], o_last};
    end
  end
  assign res_count = sink_cnt;
  assign res_last  = sink_lp[1];

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int exp_count();
    int c = 0;
    for (int i = 1; i < model_q.size(); i++)
      if (model_q[i] > model_q[i-1]) c++;
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},   64'(o_data),    64'(32'hFFFF_FFFF));
    check({tag, "_last"},   64'(o_last),    64'd0);
    check({tag, "_sink"},   64'(sink_rstn), 64'd1);
    check({tag, "_result"}, 64'(o_result),  64'd0);
    check({tag, "_loaded"}, 64'(o_loaded),  64'd0);
    check({tag, "_busy"},   64'(o_busy),    64'd0);
    check({tag, "_done"},   64'(o_done),    64'd0);
    check({tag, "_ovf"},    64'(o_ovf),     64'd0);
  endtask

  task automatic write_sample(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    else model_ovf = 1'b1;
    check("wr_loaded", 64'(o_loaded), 64'(model_q.size()));
    check("wr_ovf",    64'(o_ovf),    64'(model_ovf));
  endtask

  task automatic clear_buf(input logic with_wr);
    clr     = 1'b1;
    wr_en   = with_wr;
    wr_data = $urandom;
    tick();
    clr   = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    check("clr_loaded", 64'(o_loaded), 64'd0);
    check("clr_ovf",    64'(o_ovf),    64'd0);
  endtask

  // Launch a run from IDLE and follow it cycle by cycle to DONE.
  task automatic run(input logic disturb);
    int n    = model_q.size();
    int expc = exp_count();
    int lat;
    logic got = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_busy", 64'(o_busy),    64'd1);
    check("clr_sink", 64'(sink_rstn), 64'd0);
    check("clr_data", 64'(o_data),    64'(32'hFFFF_FFFF));
    check("clr_last", 64'(o_last),    64'd0);
    for (int k = 0; k < n; k++) begin
      if (disturb && k == 1) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        start   = 1'b1;
        clr     = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      clr   = 1'b0;
      check("play_data", 64'(o_data),    64'(model_q[k]));
      check("play_last", 64'(o_last),    64'(k == n - 1));
      check("play_sink", 64'(sink_rstn), 64'd1);
      check("play_busy", 64'(o_busy),    64'd1);
      check("play_done", 64'(o_done),    64'd0);
    end
    lat = n + 1;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      lat++;
      if (o_done) begin
        got = 1'b1;
      end else begin
        check("wait_data", 64'(o_data), 64'(model_q[n-1]));
        check("wait_last", 64'(o_last), 64'd0);
      end
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("latency",     64'(lat),      64'(n + 4));
      check("done_result", 64'(o_result), 64'(expc));
      check("done_busy",   64'(o_busy),   64'd1);
      tick();
      check("post_done",   64'(o_done),   64'd0);
      check("post_busy",   64'(o_busy),   64'd0);
      check("post_result", 64'(o_result), 64'(expc));
      check("post_loaded", 64'(o_loaded), 64'(n));
    end
  endtask

  initial begin
    logic [DW-1:0] basic [10] = '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263};
    logic [DW-1:0] flat  [5]  = '{3, 3, 3, 2, 1};
    int n;

    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    clr       = 1'b0;
    start     = 1'b0;
    model_ovf = 1'b0;
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("idle");

    // Start with an empty buffer is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", 64'(o_busy),    64'd0);
    check("empty_start_sink", 64'(sink_rstn), 64'd1);
    tick();
    check("empty_start_busy2", 64'(o_busy), 64'd0);

    // Basic run, then a replay disturbed by ignored inputs.
    foreach (basic[i]) write_sample(basic[i]);
    run(1'b0);
    check("basic_result", 64'(o_result), 64'd7);
    run(1'b1);
    check("replay_result", 64'(o_result), 64'd7);
    check("replay_loaded", 64'(o_loaded), 64'd10);

    // Single sample.
    clear_buf(1'b0);
    write_sample(5);
    run(1'b0);
    check("single_result", 64'(o_result), 64'd0);

    // Flat and decreasing data.
    clear_buf(1'b0);
    foreach (flat[i]) write_sample(flat[i]);
    run(1'b0);
    check("flat_result", 64'(o_result), 64'd0);

    // Overflow, full-buffer run, clear priority over write.
    clear_buf(1'b0);
    for (int i = 0; i < DEPTH + 2; i++) write_sample(DW'($urandom_range(0, 100)));
    check("ovf_loaded", 64'(o_loaded), 64'(DEPTH));
    check("ovf_flag",   64'(o_ovf),    64'd1);
    run(1'b0);
    check("ovf_kept", 64'(o_ovf), 64'd1);
    clear_buf(1'b1);

    // Asynchronous reset in the middle of PLAY.
    for (int i = 0; i < 6; i++) write_sample(DW'($urandom_range(0, 50)));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    tick();
    check_reset_outputs("after_rst");

    // Randomized runs against the reference model.
    for (int it = 0; it < 12; it++) begin
      clear_buf(1'b0);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        if (it % 2 == 0) write_sample(DW'($urandom_range(0, 7)));
        else write_sample(DW'($urandom));
      end
      run((n >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
